csi_rx_capture_ctrl: RTL and testbench
======================================

Name: csi_rx_capture_ctrl

Overview:
Frame-capture sequencer behind the CSI-2 packet handler, in the word_clk domain. The host arms it, and it then skips a configurable number of frames. It gates the 32-bit payload stream into one frame (single-shot) or successive frames (continuous), and checks words-per-line and lines-per-frame against expected geometry. It emits sof, line-end and frame-end strobes plus sticky error/status flags for the downstream frame writer.

Parameters:
WCNT_W, 16, width of per-line word counter and exp_words
LCNT_W, 16, width of per-frame line counter and exp_lines
FCNT_W, 8, width of captured-frame counter
TIMEOUT, 24'd16777215, word_clk cycles allowed in WAIT_FS before timeout error

Ports:
clock  in  1  word clock; single clock domain
reset  in  1  synchronous, active-high
arm  in  1  start-capture pulse
abort  in  1  stop request pulse
continuous  in  1  1 = re-arm after every frame; sampled on arm
skip_frames  in  4  complete frames to discard before capture; sampled on arm
exp_words  in  WCNT_W  expected payload words per line; sampled on arm
exp_lines  in  LCNT_W  expected lines per frame; sampled on arm
vsync  in  1  one-cycle frame-start pulse from packet handler
in_frame  in  1  high between FS and FE
payload_data  in  32  payload word
payload_enable  in  1  payload word valid
payload_frame  in  1  high for duration of a long packet
out_data  out  32  gated payload
out_valid  out  1  out_data valid
out_sof  out  1  with first out_valid of a captured frame
out_eol  out  1  one-cycle line-end strobe (out_valid=0)
out_eof  out  1  one-cycle frame-end strobe (out_valid=0)
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on capture completion
frame_count  out  FCNT_W  frames captured since arm, wraps
err_line_len  out  1  sticky: a line's word count != exp_words
err_line_count  out  1  sticky: a frame's line count != exp_lines
err_sync  out  1  sticky: vsync while capturing before frame end
err_timeout  out  1  sticky: no frame start within TIMEOUT

Behaviour:
- All outputs registered. Reset values: out_data=0 and all other outputs 0, FSM=IDLE, edge-detect regs (prev in_frame, prev payload_frame)=0.
- Frame end = in_frame falling edge (prev=1, now=0). Line end = payload_frame falling edge.
- States:
  - IDLE: arm → WAIT_FS. On arm, latch config, clear sticky errors and frame_count, set skip_ctr=skip_frames, clear timeout ctr. Otherwise stay.
  - WAIT_FS: vsync → SKIP if skip_ctr!=0, else CAPTURE. The frame-start cycle clears word/line counters. Timeout ctr increments each cycle; at TIMEOUT set err_timeout and go → IDLE; no done pulse.
  - SKIP: frame end → decrement skip_ctr → WAIT_FS (timeout ctr cleared). Payload ignored.
  - CAPTURE: passes payload only while in this state; out_valid = payload_enable, out_data = payload_data, 1-cycle latency. out_sof is set on the first valid word after frame start.
    - Line end: out_eol=1 next cycle. Set err_line_len if word ctr != latched exp_words. Line ctr +1 (saturating). Word ctr cleared. Word ctr saturates at all-ones.
    - Frame end: out_eof=1 next cycle. Set err_line_count if line ctr != exp_lines. frame_count +1, wrapping.
    - After frame end: continuous and no pending abort → WAIT_FS (skip_ctr stays 0). Otherwise → DONE.
    - vsync while in CAPTURE with in_frame still high (missed FE): set err_sync, restart word/line ctrs, rearm sof, stay in CAPTURE. No eof and no frame_count increment.
  - DONE: done=1 for one cycle → IDLE.
- abort: in IDLE ignored. In WAIT_FS/SKIP → IDLE next cycle, no done. In CAPTURE it is latched as pending and the current frame finishes normally, then → DONE.
- arm while busy: ignored. arm and abort in the same cycle in IDLE: arm wins (abort ignored in IDLE).
- Line-end and frame-end in the same cycle: process line first (eol and eof both asserted next cycle); the line is counted before the exp_lines compare.
- Words arriving with payload_frame low are still passed in CAPTURE and counted.
- Synchronous reset mid-capture: all outputs and state to reset values next edge; no done pulse.

Test Plan:
- Single-shot, skip=0, exp_words=4, exp_lines=3: arm, then one frame of 3 lines × 4 words → 12 out_valid, out_sof on word 1, 3 out_eol, 1 out_eof, done pulse, frame_count=1, no errors, busy=0 after.
- Skip=2, continuous=0: arm, 3 frames → only frame 3 passed; out_valid count equals frame-3 words.
- Geometry errors: line 2 carries 5 words and frame has 2 lines with exp 4/3 → err_line_len=1, err_line_count=1, both held until next arm.
- Continuous mode, 3 frames, abort mid-frame 2 → frames 1 and 2 fully passed, frame_count=2, done after frame 2's eof, frame 3 not passed.
- Timeout: TIMEOUT=100, arm, no vsync → err_timeout at cycle 100, IDLE, done=0. Separately, vsync mid-CAPTURE → err_sync=1 and sof on the next word.
- Reset asserted mid-line → next cycle every output is 0 and the FSM is in IDLE; a subsequent arm captures normally.

Source files
------------

// File: rtl/csi_rx_capture_ctrl_if.sv
// Payload stream from the CSI-2 packet handler and gated stream to the frame writer.
// The slave modport is the capture controller's view; master is the surrounding logic.
interface csi_rx_capture_ctrl_if;
   logic        vsync;
   logic        in_frame;
   logic [31:0] payload_data;
   logic        payload_enable;
   logic        payload_frame;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_sof;
   logic        out_eol;
   logic        out_eof;

   modport master (
      output vsync, in_frame, payload_data, payload_enable, payload_frame,
      input  out_data, out_valid, out_sof, out_eol, out_eof
   );

   modport slave (
      input  vsync, in_frame, payload_data, payload_enable, payload_frame,
      output out_data, out_valid, out_sof, out_eol, out_eof
   );
endinterface

// File: rtl/csi_rx_capture_ctrl.sv
// Frame-capture sequencer: arm, skip N frames, gate payload of one or successive
// frames, check line/frame geometry and raise sticky error flags.
module csi_rx_capture_ctrl #(
   parameter int unsigned WCNT_W  = 16,
   parameter int unsigned LCNT_W  = 16,
   parameter int unsigned FCNT_W  = 8,
   parameter logic [23:0] TIMEOUT = 24'd16777215
) (
   input  logic                  clock_i,
   input  logic                  reset_i,
   input  logic                  arm_i,
   input  logic                  abort_i,
   input  logic                  continuous_i,
   input  logic [3:0]            skip_frames_i,
   input  logic [WCNT_W-1:0]     exp_words_i,
   input  logic [LCNT_W-1:0]     exp_lines_i,
   csi_rx_capture_ctrl_if.slave  bus,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [FCNT_W-1:0]     frame_count_o,
   output logic                  err_line_len_o,
   output logic                  err_line_count_o,
   output logic                  err_sync_o,
   output logic                  err_timeout_o
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WAIT_FS = 3'd1,
      ST_SKIP    = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_DONE    = 3'd4
   } state_e;

   state_e              state_q, state_d;
   logic                cont_q, cont_d;
   logic [WCNT_W-1:0]   exp_words_q, exp_words_d;
   logic [LCNT_W-1:0]   exp_lines_q, exp_lines_d;
   logic [3:0]          skip_ctr_q, skip_ctr_d;
   logic [23:0]         tmo_q, tmo_d;
   logic [WCNT_W-1:0]   word_ctr_q, word_ctr_d;
   logic [LCNT_W-1:0]   line_ctr_q, line_ctr_d;
   logic                sof_pend_q, sof_pend_d;
   logic                abort_pend_q, abort_pend_d;
   logic                prev_in_frame_q, prev_pframe_q;

   logic [31:0]         out_data_q, out_data_d;
   logic                out_valid_q, out_valid_d;
   logic                out_sof_q, out_sof_d;
   logic                out_eol_q, out_eol_d;
   logic                out_eof_q, out_eof_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [FCNT_W-1:0]   frame_count_q, frame_count_d;
   logic                err_line_len_q, err_line_len_d;
   logic                err_line_count_q, err_line_count_d;
   logic                err_sync_q, err_sync_d;
   logic                err_timeout_q, err_timeout_d;

   logic                frame_end;
   logic                line_end;
   logic                sync_restart;
   logic                sof_now;
   logic [WCNT_W-1:0]   word_base, word_next;
   logic [LCNT_W-1:0]   line_base, line_next;

   assign frame_end = prev_in_frame_q & ~bus.in_frame;
   assign line_end  = prev_pframe_q & ~bus.payload_frame;
   // A second frame start while the frame is still open means FE was lost.
   assign sync_restart = bus.vsync & prev_in_frame_q & bus.in_frame;

   // Next-state, counter and output-register decode.
   always_comb begin
      state_d          = state_q;
      cont_d           = cont_q;
      exp_words_d      = exp_words_q;
      exp_lines_d      = exp_lines_q;
      skip_ctr_d       = skip_ctr_q;
      tmo_d            = tmo_q;
      word_ctr_d       = word_ctr_q;
      line_ctr_d       = line_ctr_q;
      sof_pend_d       = sof_pend_q;
      abort_pend_d     = abort_pend_q;
      out_data_d       = 32'd0;
      out_valid_d      = 1'b0;
      out_sof_d        = 1'b0;
      out_eol_d        = 1'b0;
      out_eof_d        = 1'b0;
      frame_count_d    = frame_count_q;
      err_line_len_d   = err_line_len_q;
      err_line_count_d = err_line_count_q;
      err_sync_d       = err_sync_q;
      err_timeout_d    = err_timeout_q;
      sof_now          = 1'b0;
      word_base        = word_ctr_q;
      word_next        = word_ctr_q;
      line_base        = line_ctr_q;
      line_next        = line_ctr_q;

      case (state_q)
         ST_IDLE: begin
            if (arm_i) begin
               state_d          = ST_WAIT_FS;
               cont_d           = continuous_i;
               exp_words_d      = exp_words_i;
               exp_lines_d      = exp_lines_i;
               skip_ctr_d       = skip_frames_i;
               tmo_d            = 24'd0;
               abort_pend_d     = 1'b0;
               frame_count_d    = '0;
               err_line_len_d   = 1'b0;
               err_line_count_d = 1'b0;
               err_sync_d       = 1'b0;
               err_timeout_d    = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_WAIT_FS: begin
            if (abort_i) begin
               state_d = ST_IDLE;
            end else if (bus.vsync) begin
               word_ctr_d = '0;
               line_ctr_d = '0;
               tmo_d      = 24'd0;
               if (skip_ctr_q != 4'd0) begin
                  state_d = ST_SKIP;
               end else begin
                  state_d    = ST_CAPTURE;
                  sof_pend_d = 1'b1;
               end
            end else if (tmo_q == (TIMEOUT - 24'd1)) begin
               err_timeout_d = 1'b1;
               state_d       = ST_IDLE;
            end else begin
               tmo_d = tmo_q + 24'd1;
            end
         end

         ST_SKIP: begin
            if (abort_i) begin
               state_d = ST_IDLE;
            end else if (frame_end) begin
               skip_ctr_d = skip_ctr_q - 4'd1;
               tmo_d      = 24'd0;
               state_d    = ST_WAIT_FS;
            end else begin
               state_d = ST_SKIP;
            end
         end

         ST_CAPTURE: begin
            if (abort_i) begin
               abort_pend_d = 1'b1;
            end else begin
               abort_pend_d = abort_pend_q;
            end

            out_valid_d = bus.payload_enable;
            out_data_d  = bus.payload_enable ? bus.payload_data : 32'd0;

            if (sync_restart) begin
               err_sync_d = 1'b1;
               word_base  = '0;
               line_base  = '0;
               sof_now    = 1'b1;
            end else begin
               sof_now    = sof_pend_q;
            end
            out_sof_d  = sof_now & bus.payload_enable;
            sof_pend_d = sof_now & ~bus.payload_enable;

            // A word arriving on the line-end cycle still belongs to the ending line.
            if (bus.payload_enable && (word_base != {WCNT_W{1'b1}})) begin
               word_next = word_base + WCNT_W'(1);
            end else begin
               word_next = word_base;
            end

            if (line_end) begin
               out_eol_d = 1'b1;
               if (word_next != exp_words_q) begin
                  err_line_len_d = 1'b1;
               end else begin
                  err_line_len_d = err_line_len_q;
               end
               if (line_base != {LCNT_W{1'b1}}) begin
                  line_next = line_base + LCNT_W'(1);
               end else begin
                  line_next = line_base;
               end
               word_ctr_d = '0;
            end else begin
               line_next  = line_base;
               word_ctr_d = word_next;
            end
            line_ctr_d = line_next;

            if (frame_end) begin
               out_eof_d     = 1'b1;
               frame_count_d = frame_count_q + FCNT_W'(1);
               word_ctr_d    = '0;
               line_ctr_d    = '0;
               if (line_next != exp_lines_q) begin
                  err_line_count_d = 1'b1;
               end else begin
                  err_line_count_d = err_line_count_q;
               end
               if (cont_q && !abort_pend_q && !abort_i) begin
                  state_d = ST_WAIT_FS;
                  tmo_d   = 24'd0;
               end else begin
                  state_d = ST_DONE;
               end
            end else begin
               state_d = ST_CAPTURE;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   // State, counters, edge-detect history and registered outputs.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q          <= ST_IDLE;
         cont_q           <= 1'b0;
         exp_words_q      <= '0;
         exp_lines_q      <= '0;
         skip_ctr_q       <= 4'd0;
         tmo_q            <= 24'd0;
         word_ctr_q       <= '0;
         line_ctr_q       <= '0;
         sof_pend_q       <= 1'b0;
         abort_pend_q     <= 1'b0;
         prev_in_frame_q  <= 1'b0;
         prev_pframe_q    <= 1'b0;
         out_data_q       <= 32'd0;
         out_valid_q      <= 1'b0;
         out_sof_q        <= 1'b0;
         out_eol_q        <= 1'b0;
         out_eof_q        <= 1'b0;
         busy_q           <= 1'b0;
         done_q           <= 1'b0;
         frame_count_q    <= '0;
         err_line_len_q   <= 1'b0;
         err_line_count_q <= 1'b0;
         err_sync_q       <= 1'b0;
         err_timeout_q    <= 1'b0;
      end else begin
         state_q          <= state_d;
         cont_q           <= cont_d;
         exp_words_q      <= exp_words_d;
         exp_lines_q      <= exp_lines_d;
         skip_ctr_q       <= skip_ctr_d;
         tmo_q            <= tmo_d;
         word_ctr_q       <= word_ctr_d;
         line_ctr_q       <= line_ctr_d;
         sof_pend_q       <= sof_pend_d;
         abort_pend_q     <= abort_pend_d;
         prev_in_frame_q  <= bus.in_frame;
         prev_pframe_q    <= bus.payload_frame;
         out_data_q       <= out_data_d;
         out_valid_q      <= out_valid_d;
         out_sof_q        <= out_sof_d;
         out_eol_q        <= out_eol_d;
         out_eof_q        <= out_eof_d;
         busy_q           <= busy_d;
         done_q           <= done_d;
         frame_count_q    <= frame_count_d;
         err_line_len_q   <= err_line_len_d;
         err_line_count_q <= err_line_count_d;
         err_sync_q       <= err_sync_d;
         err_timeout_q    <= err_timeout_d;
      end
   end

   assign bus.out_data     = out_data_q;
   assign bus.out_valid    = out_valid_q;
   assign bus.out_sof      = out_sof_q;
   assign bus.out_eol      = out_eol_q;
   assign bus.out_eof      = out_eof_q;
   assign busy_o           = busy_q;
   assign done_o           = done_q;
   assign frame_count_o    = frame_count_q;
   assign err_line_len_o   = err_line_len_q;
   assign err_line_count_o = err_line_count_q;
   assign err_sync_o       = err_sync_q;
   assign err_timeout_o    = err_timeout_q;

endmodule

// File: tb/tb_csi_rx_capture_ctrl.sv
// Directed bench for csi_rx_capture_ctrl: single-shot, skip, geometry errors,
// continuous with abort, timeout, missed frame end and reset mid-line.
module tb_csi_rx_capture_ctrl;

   logic        clk = 1'b0;
   logic        reset_i;
   logic        arm_i;
   logic        abort_i;
   logic        continuous_i;
   logic [3:0]  skip_frames_i;
   logic [15:0] exp_words_i;
   logic [15:0] exp_lines_i;
   logic        busy_o;
   logic        done_o;
   logic [7:0]  frame_count_o;
   logic        err_line_len_o;
   logic        err_line_count_o;
   logic        err_sync_o;
   logic        err_timeout_o;

   int n_checks = 0;
   int n_fail   = 0;

   int          n_valid = 0, n_sof = 0, n_eol = 0, n_eof = 0, n_done = 0;
   int          sof_pos = 0, eof_at_done = 0;
   logic [31:0] sof_data = 32'd0;
   int          b_valid, b_sof, b_eol, b_eof, b_done;

   csi_rx_capture_ctrl_if bus_if ();

   csi_rx_capture_ctrl #(
      .WCNT_W  (16),
      .LCNT_W  (16),
      .FCNT_W  (8),
      .TIMEOUT (24'd100)
   ) dut (
      .clock_i          (clk),
      .reset_i          (reset_i),
      .arm_i            (arm_i),
      .abort_i          (abort_i),
      .continuous_i     (continuous_i),
      .skip_frames_i    (skip_frames_i),
      .exp_words_i      (exp_words_i),
      .exp_lines_i      (exp_lines_i),
      .bus              (bus_if),
      .busy_o           (busy_o),
      .done_o           (done_o),
      .frame_count_o    (frame_count_o),
      .err_line_len_o   (err_line_len_o),
      .err_line_count_o (err_line_count_o),
      .err_sync_o       (err_sync_o),
      .err_timeout_o    (err_timeout_o)
   );

   always #5 clk = ~clk;

   // Output event counters, sampled on the falling edge.
   always @(negedge clk) begin
      if (bus_if.out_valid) n_valid++;
      if (bus_if.out_sof) begin
         n_sof++;
         sof_pos  = n_valid;
         sof_data = bus_if.out_data;
      end
      if (bus_if.out_eol) n_eol++;
      if (bus_if.out_eof) n_eof++;
      if (done_o) begin
         n_done++;
         eof_at_done = n_eof;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic snap();
      b_valid = n_valid; b_sof = n_sof; b_eol = n_eol; b_eof = n_eof; b_done = n_done;
   endtask

   task automatic arm_cfg(input logic cont, input logic [3:0] skip, input logic [15:0] w,
                          input logic [15:0] l, input logic with_abort);
      continuous_i  = cont;
      skip_frames_i = skip;
      exp_words_i   = w;
      exp_lines_i   = l;
      arm_i         = 1'b1;
      abort_i       = with_abort;
      tick();
      arm_i   = 1'b0;
      abort_i = 1'b0;
   endtask

   // One frame: FS, lines of payload with a gap after each, FE. -1 disables an option.
   task automatic send_frame(input int fid, input int nlines, input int wpl, input int long_line,
                             input int long_words, input int abort_line, input int sync_line);
      int nw;
      bus_if.vsync    = 1'b1;
      bus_if.in_frame = 1'b1;
      tick();
      bus_if.vsync = 1'b0;
      tick();
      for (int l = 0; l < nlines; l++) begin
         if (l == sync_line) begin
            bus_if.vsync = 1'b1;
            tick();
            bus_if.vsync = 1'b0;
         end
         nw = (l == long_line) ? long_words : wpl;
         bus_if.payload_frame = 1'b1;
         for (int w = 0; w < nw; w++) begin
            bus_if.payload_enable = 1'b1;
            bus_if.payload_data   = {8'(fid + 160), 8'(l), 16'(w)};
            abort_i               = (l == abort_line) && (w == 0);
            tick();
         end
         abort_i               = 1'b0;
         bus_if.payload_enable = 1'b0;
         bus_if.payload_data   = 32'd0;
         bus_if.payload_frame  = 1'b0;
         ticks(2);
      end
      bus_if.in_frame = 1'b0;
      ticks(3);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_i = 1'b1; arm_i = 1'b0; abort_i = 1'b0; continuous_i = 1'b0;
      skip_frames_i = 4'd0; exp_words_i = 16'd0; exp_lines_i = 16'd0;
      bus_if.vsync = 1'b0; bus_if.in_frame = 1'b0; bus_if.payload_data = 32'd0;
      bus_if.payload_enable = 1'b0; bus_if.payload_frame = 1'b0;
      ticks(3);
      reset_i = 1'b0;
      tick();
      check_eq("rst_out_valid", bus_if.out_valid, 32'd0);
      check_eq("rst_out_data", bus_if.out_data, 32'd0);
      check_eq("rst_busy", busy_o, 32'd0);
      check_eq("rst_frame_count", frame_count_o, 32'd0);

      // Single-shot, 3 lines x 4 words.
      snap();
      arm_cfg(1'b0, 4'd0, 16'd4, 16'd3, 1'b0);
      check_eq("t1_busy_after_arm", busy_o, 32'd1);
      send_frame(1, 3, 4, -1, 0, -1, -1);
      check_eq("t1_valid", n_valid - b_valid, 32'd12);
      check_eq("t1_sof_pos", sof_pos - b_valid, 32'd1);
      check_eq("t1_sof_data", sof_data, 32'hA100_0000);
      check_eq("t1_eol", n_eol - b_eol, 32'd3);
      check_eq("t1_eof", n_eof - b_eof, 32'd1);
      check_eq("t1_done", n_done - b_done, 32'd1);
      check_eq("t1_frame_count", frame_count_o, 32'd1);
      check_eq("t1_errs", {err_line_len_o, err_line_count_o, err_sync_o, err_timeout_o}, 32'd0);
      check_eq("t1_busy_end", busy_o, 32'd0);

      // Skip two frames, capture the third.
      snap();
      arm_cfg(1'b0, 4'd2, 16'd4, 16'd3, 1'b0);
      send_frame(1, 3, 4, -1, 0, -1, -1);
      send_frame(2, 3, 4, -1, 0, -1, -1);
      send_frame(3, 3, 4, -1, 0, -1, -1);
      check_eq("t2_valid", n_valid - b_valid, 32'd12);
      check_eq("t2_sof_count", n_sof - b_sof, 32'd1);
      check_eq("t2_sof_data", sof_data, 32'hA300_0000);
      check_eq("t2_eof", n_eof - b_eof, 32'd1);
      check_eq("t2_done", n_done - b_done, 32'd1);
      check_eq("t2_frame_count", frame_count_o, 32'd1);

      // Geometry errors: 2 lines of 4 and 5 words against 4/3.
      snap();
      arm_cfg(1'b0, 4'd0, 16'd4, 16'd3, 1'b0);
      send_frame(4, 2, 4, 1, 5, -1, -1);
      check_eq("t3_valid", n_valid - b_valid, 32'd9);
      check_eq("t3_err_line_len", err_line_len_o, 32'd1);
      check_eq("t3_err_line_count", err_line_count_o, 32'd1);
      ticks(10);
      check_eq("t3_len_held", err_line_len_o, 32'd1);
      check_eq("t3_count_held", err_line_count_o, 32'd1);

      // Continuous, abort during frame 2; arm between frames must be ignored.
      snap();
      arm_cfg(1'b1, 4'd0, 16'd4, 16'd3, 1'b0);
      check_eq("t4_errs_cleared", {err_line_len_o, err_line_count_o}, 32'd0);
      send_frame(1, 3, 4, -1, 0, -1, -1);
      arm_cfg(1'b0, 4'd5, 16'd9, 16'd9, 1'b0);
      send_frame(2, 3, 4, -1, 0, 1, -1);
      send_frame(3, 3, 4, -1, 0, -1, -1);
      check_eq("t4_valid", n_valid - b_valid, 32'd24);
      check_eq("t4_sof_count", n_sof - b_sof, 32'd2);
      check_eq("t4_eof", n_eof - b_eof, 32'd2);
      check_eq("t4_done", n_done - b_done, 32'd1);
      check_eq("t4_done_at_eof", eof_at_done - b_eof, 32'd2);
      check_eq("t4_frame_count", frame_count_o, 32'd2);
      check_eq("t4_errs", {err_line_len_o, err_line_count_o, err_sync_o}, 32'd0);
      check_eq("t4_busy_end", busy_o, 32'd0);

      // Timeout with no frame start; arm with simultaneous abort still arms.
      snap();
      arm_cfg(1'b0, 4'd0, 16'd4, 16'd3, 1'b1);
      check_eq("t5_busy_arm_abort", busy_o, 32'd1);
      ticks(99);
      check_eq("t5_no_timeout_yet", err_timeout_o, 32'd0);
      check_eq("t5_busy_before", busy_o, 32'd1);
      tick();
      check_eq("t5_err_timeout", err_timeout_o, 32'd1);
      check_eq("t5_idle", busy_o, 32'd0);
      check_eq("t5_no_done", n_done - b_done, 32'd0);

      // Missed frame end: second FS after line 0, then 3 clean lines.
      snap();
      arm_cfg(1'b0, 4'd0, 16'd4, 16'd3, 1'b0);
      check_eq("t6_timeout_cleared", err_timeout_o, 32'd0);
      send_frame(6, 4, 4, -1, 0, -1, 1);
      check_eq("t6_err_sync", err_sync_o, 32'd1);
      check_eq("t6_sof_count", n_sof - b_sof, 32'd2);
      check_eq("t6_sof_data", sof_data, 32'hA601_0000);
      check_eq("t6_valid", n_valid - b_valid, 32'd16);
      check_eq("t6_eof", n_eof - b_eof, 32'd1);
      check_eq("t6_frame_count", frame_count_o, 32'd1);
      check_eq("t6_geom_ok", {err_line_len_o, err_line_count_o}, 32'd0);

      // Reset in the middle of a line.
      snap();
      arm_cfg(1'b0, 4'd0, 16'd4, 16'd3, 1'b0);
      bus_if.vsync = 1'b1; bus_if.in_frame = 1'b1;
      tick();
      bus_if.vsync = 1'b0; bus_if.payload_frame = 1'b1;
      bus_if.payload_enable = 1'b1; bus_if.payload_data = 32'hDEAD_BEEF;
      ticks(2);
      check_eq("t7_valid_pre_reset", bus_if.out_valid, 32'd1);
      reset_i = 1'b1;
      tick();
      check_eq("t7_out_valid", bus_if.out_valid, 32'd0);
      check_eq("t7_out_data", bus_if.out_data, 32'd0);
      check_eq("t7_busy", busy_o, 32'd0);
      check_eq("t7_flags", {done_o, err_line_len_o, err_line_count_o, err_sync_o, err_timeout_o,
                            bus_if.out_sof, bus_if.out_eol, bus_if.out_eof}, 32'd0);
      check_eq("t7_frame_count", frame_count_o, 32'd0);
      reset_i = 1'b0;
      bus_if.payload_enable = 1'b0; bus_if.payload_frame = 1'b0;
      bus_if.payload_data = 32'd0; bus_if.in_frame = 1'b0;
      ticks(2);
      check_eq("t7_no_done", n_done - b_done, 32'd0);
      snap();
      arm_cfg(1'b0, 4'd0, 16'd4, 16'd3, 1'b0);
      send_frame(7, 3, 4, -1, 0, -1, -1);
      check_eq("t7_recap_valid", n_valid - b_valid, 32'd12);
      check_eq("t7_recap_done", n_done - b_done, 32'd1);
      check_eq("t7_recap_frames", frame_count_o, 32'd1);
      check_eq("t7_recap_errs", {err_line_len_o, err_line_count_o, err_sync_o, err_timeout_o}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
